ob_buf_loader: RTL and testbench

//  Upstream feeder for the PCIe sub-controller's outbound (Ob) RAM.

---
 rtl/ob_buf_loader.sv | 177 +++++++++++++++++
 tb/tb_ob_buf_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ob_buf_loader.sv
// ---------------------------------------------------------------------------
// ob_buf_loader
//
// Feeds the outbound (Ob) RAM of the PCIe sub-controller from a 128-bit
// valid/ready stream. Each accepted beat is written into Ob RAM one cycle
// later at BASE_ADDR + beat index. A buffer closes on an accepted beat with
// s_last=1 or on the DEPTH-th accepted beat, whichever comes first. After
// closing, a one-cycle ObDataValid pulse hands the buffer to the controller.
// The block then waits for the controller to drop ObRamValid before it
// returns to idle.
//
// Handshake (s_valid / s_ready / s_data / s_last):
//   A beat transfers on a rising edge where s_valid and s_ready are both 1.
//   s_ready depends only on the FSM state, never on s_valid. A beat offered
//   while s_ready=0 is not consumed, and the source must hold it.
//
// Parameters
//   DEPTH      beats per Ob buffer; a power of 2, >= 2
//   ADDR_W     width of ObAddrIn
//   BASE_ADDR  Ob RAM address of beat 0; address arithmetic wraps mod 2^ADDR_W
//
// Ports
//   clk          clock; all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   s_valid      stream beat valid
//   s_data       stream beat data (128 bits)
//   s_last       beat closes the current buffer early
//   s_ready      block accepts a beat this cycle
//   ObWrEn       Ob RAM write strobe (registered, 1 cycle after accept)
//   ObAddrIn     Ob RAM write address (holds when no write)
//   ObDataIn     Ob RAM write data (holds when no write)
//   ObDataValid  1-cycle pulse: buffer complete, handed to controller
//   ObRamValid   controller: Ob RAM is empty and may be filled
//   fill_cnt     beats committed in the most recent buffer (1..DEPTH)
//   busy         FSM is not idle
// ---------------------------------------------------------------------------
module ob_buf_loader #(
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [127:0]             s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     ObWrEn,
  output logic [ADDR_W-1:0]        ObAddrIn,
  output logic [127:0]             ObDataIn,
  output logic                     ObDataValid,
  input  logic                     ObRamValid,
  output logic [$clog2(DEPTH):0]   fill_cnt,
  output logic                     busy
);

  // One spare bit so the counter can hold DEPTH itself after a full buffer.
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   idx_q;
  logic               accept;
  logic               at_last_idx;
  logic               close_buf;

  // -------------------------------------------------------------------------
  // Handshake and buffer-close detection
  // -------------------------------------------------------------------------
  assign s_ready     = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign accept      = s_valid & s_ready;
  assign at_last_idx = (idx_q == CNT_W'(DEPTH - 1));
  // s_last on the final slot and a full count are the same single close event.
  assign close_buf   = accept & (s_last | at_last_idx);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ObRamValid) begin
          state_d = FILL;
        end
      end
      FILL: begin
        // ObRamValid is deliberately not looked at here: the controller
        // keeps it asserted while a buffer is being filled.
        if (close_buf) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // Wait until the controller has taken the buffer so a new fill
        // cannot start before it has seen ObDataValid.
        if (!ObRamValid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Beat index: cleared on the way into FILL, advanced on each accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if ((state_q == IDLE) && ObRamValid) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Ob RAM write port: one cycle after accept. Address and data hold their
  // last value on cycles without a write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ObWrEn   <= 1'b0;
      ObAddrIn <= '0;
      ObDataIn <= '0;
    end else begin
      ObWrEn <= accept;
      if (accept) begin
        ObAddrIn <= BASE_ADDR + ADDR_W'(idx_q);
        ObDataIn <= s_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hand-off: the pulse is registered from COMMIT. The final beat's write
  // strobe is visible during COMMIT, so the pulse lands one cycle after it.
  // fill_cnt is captured at the same edge and held until the next buffer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ObDataValid <= 1'b0;
      fill_cnt    <= '0;
    end else begin
      ObDataValid <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        fill_cnt <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_ob_buf_loader.sv
// ---------------------------------------------------------------------------
// tb_ob_buf_loader
//
// Three instances share one stream: base addresses 0, 0x100 and 0xFFFFFFFE.
// Expected behaviour comes from the transfer-level rules. Each accepted beat
// is pushed to an expected queue and must appear as a write one cycle later
// at base + index. The close cycle is followed by the hand-off pulse with
// the beat count on the next cycle. The block then waits in a busy drain
// state until ObRamValid drops.
// ---------------------------------------------------------------------------
module tb_ob_buf_loader;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int CW    = 7;
  localparam logic [AW-1:0] BASE0 = 32'h0000_0000;
  localparam logic [AW-1:0] BASE1 = 32'h0000_0100;
  localparam logic [AW-1:0] BASE2 = 32'hFFFF_FFFE;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_last;
  logic         ob_ram_valid;

  // per-instance outputs
  logic [NDUT-1:0]          s_ready;
  logic [NDUT-1:0]          wr_en;
  logic [NDUT-1:0][AW-1:0]  addr;
  logic [NDUT-1:0][127:0]   dout;
  logic [NDUT-1:0]          dv;
  logic [NDUT-1:0][CW-1:0]  cnt;
  logic [NDUT-1:0]          busy;

  ob_buf_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready[0]), .ObWrEn(wr_en[0]), .ObAddrIn(addr[0]), .ObDataIn(dout[0]),
    .ObDataValid(dv[0]), .ObRamValid(ob_ram_valid), .fill_cnt(cnt[0]), .busy(busy[0]));
  ob_buf_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready[1]), .ObWrEn(wr_en[1]), .ObAddrIn(addr[1]), .ObDataIn(dout[1]),
    .ObDataValid(dv[1]), .ObRamValid(ob_ram_valid), .fill_cnt(cnt[1]), .busy(busy[1]));
  ob_buf_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE2)) u2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready[2]), .ObWrEn(wr_en[2]), .ObAddrIn(addr[2]), .ObDataIn(dout[2]),
    .ObDataValid(dv[2]), .ObRamValid(ob_ram_valid), .fill_cnt(cnt[2]), .busy(busy[2]));

  // scoreboard / reference state
  logic [127:0]  exp_q[$];
  logic [AW-1:0] base [NDUT];
  logic [AW-1:0] last_addr [NDUT];
  logic [127:0]  last_data;
  int            last_cnt;
  int            beat_idx;
  int            n_cmp;
  int            n_mis;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int k = 0; k < NDUT; k++) last_addr[k] = '0;
    last_data = '0;
    last_cnt  = 0;
    beat_idx  = 0;
  endtask

  // Compare every output of every instance with the expected values.
  task automatic check_outputs(input bit exp_wr, input bit exp_ready, input bit exp_busy,
                               input bit exp_dv, input string tag);
    if (exp_wr) begin
      if (exp_q.size() != 0) last_data = exp_q.pop_front();
      for (int k = 0; k < NDUT; k++) last_addr[k] = base[k] + AW'(beat_idx);
      beat_idx++;
    end
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s.wr_en%0d", tag, k), 128'(wr_en[k]),   128'(exp_wr));
      chk($sformatf("%s.addr%0d", tag, k),  128'(addr[k]),    128'(last_addr[k]));
      chk($sformatf("%s.data%0d", tag, k),  dout[k],          last_data);
      chk($sformatf("%s.ready%0d", tag, k), 128'(s_ready[k]), 128'(exp_ready));
      chk($sformatf("%s.busy%0d", tag, k),  128'(busy[k]),    128'(exp_busy));
      chk($sformatf("%s.dv%0d", tag, k),    128'(dv[k]),      128'(exp_dv));
      chk($sformatf("%s.cnt%0d", tag, k),   128'(cnt[k]),     128'(last_cnt));
    end
  endtask

  // One cycle while filling: offer (or not) a random beat, then check.
  task automatic beat_cycle(input bit v, input bit last, input bit exp_ready_after,
                            input string tag);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    s_valid = v;
    s_data  = d;
    s_last  = last;
    tick();
    if (v) exp_q.push_back(d);
    check_outputs(v, exp_ready_after, 1'b1, 1'b0, tag);
  endtask

  // Whole buffer: enter, fill n beats, hand off, optional DRAIN hold, release.
  task automatic run_buffer(input int n, input bit use_last, input int pct, input int hold,
                            input bit drop_in_fill, input string tag);
    int  accepted;
    int  cycles;
    bit  v;
    bit  closing;
    bit  last;
    ob_ram_valid = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    beat_idx = 0;
    check_outputs(1'b0, 1'b1, 1'b1, 1'b0, {tag, ".enter"});
    if (drop_in_fill) ob_ram_valid = 1'b0;
    accepted = 0;
    cycles   = 0;
    while (accepted < n) begin
      v = (pct >= 100) || (cycles > 600) || ($urandom_range(0, 99) < pct);
      closing = v && (accepted == n - 1);
      // s_last on an idle cycle must be ignored, so randomise it there.
      last = v ? (use_last && closing) : 1'($urandom_range(0, 1));
      beat_cycle(v, last, !closing, {tag, ".beat"});
      if (v) accepted++;
      cycles++;
    end
    // Next edge: pulse and count; keep offering a beat that must not be taken.
    s_valid = 1'b1;
    s_data  = {$urandom, $urandom, $urandom, $urandom};
    s_last  = 1'b0;
    tick();
    last_cnt = n;
    check_outputs(1'b0, 1'b0, 1'b1, 1'b1, {tag, ".handoff"});
    for (int h = 0; h < hold; h++) begin
      tick();
      check_outputs(1'b0, 1'b0, 1'b1, 1'b0, {tag, ".drain"});
    end
    ob_ram_valid = 1'b0;
    s_valid = 1'b0;
    tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, {tag, ".idle"});
  endtask

  initial begin
    int n;
    bit ul;
    n_cmp = 0;
    n_mis = 0;
    base[0] = BASE0;
    base[1] = BASE1;
    base[2] = BASE2;
    clear_model();
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    ob_ram_valid = 1'b0;

    // reset state
    repeat (3) tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    tick();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, "post_reset_idle");

    // reset in the middle of a fill after 3 beats
    ob_ram_valid = 1'b1;
    tick();
    beat_idx = 0;
    check_outputs(1'b0, 1'b1, 1'b1, 1'b0, "t1.enter");
    repeat (3) beat_cycle(1'b1, 1'b0, 1'b1, "t1.beat");
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, "t1.async_rst");
    ob_ram_valid = 1'b0;
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, "t1.after_rst");
    end

    run_buffer(DEPTH, 1'b0, 100, 0, 1'b0, "t2_full");
    run_buffer(5,     1'b1, 100, 0, 1'b0, "t3_early");
    run_buffer(DEPTH, 1'b0, 50,  0, 1'b0, "t4_gaps");
    run_buffer(7,     1'b1, 70,  3, 1'b0, "t5_hold");
    run_buffer(4,     1'b1, 100, 1, 1'b0, "t6_wrap");
    run_buffer(DEPTH, 1'b1, 100, 0, 1'b0, "t_last_on_full");
    run_buffer(1,     1'b1, 100, 0, 1'b0, "t_single");
    run_buffer(9,     1'b1, 60,  0, 1'b1, "t_drop_in_fill");
    repeat (4) begin
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      run_buffer(n, ul, $urandom_range(30, 100), $urandom_range(0, 3), 1'b0, "t_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
